// File: rtl/mem_pkt_tx_pkg.sv
// Shared constants, register map and FSM state type
// for the memory-backed packet transmitter.
package mem_pkt_tx_pkg;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_BODY = 2'b00;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    // Word offsets, i.e. addr[9:2]
    localparam logic [7:0] OFF_CTRL = 8'h00;
    localparam logic [7:0] OFF_LEN  = 8'h01;
    localparam logic [7:0] OFF_STAT = 8'h02;

    localparam logic [10:0] LEN_MIN = 11'd32;
    localparam logic [10:0] LEN_MAX = 11'd512;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_SEND
    } state_t;

    function automatic logic [6:0] beat_count(input logic [10:0] len);
        logic [11:0] sum;
        sum = {1'b0, len} + 12'd15;
        return 7'(sum >> 4);
    endfunction

endpackage

// File: rtl/mem_pkt_tx_buf.sv
// Simple dual-port packet buffer: 32-bit lane writes,
// full 128-bit beat read with one cycle of latency.
module mem_pkt_tx_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [127:0]  q
);

    logic [127:0] mem [DEPTH];

    // Lane 0 is the most significant word (network order)
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (we[l]) begin
                mem[waddr][127-32*l -: 32] <= wdata;
            end
        end
        q <= mem[raddr];
    end

endmodule

// File: rtl/mem_pkt_tx.sv
// Register-programmed packet transmitter: software fills
// the buffer, sets LEN and starts; beats stream out tagged.
module mem_pkt_tx
    import mem_pkt_tx_pkg::*;
#(
    parameter int BUF_BEATS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  addr_32b_i,
    input  logic         wren_i,
    input  logic         rden_i,
    input  logic [31:0]  din_32b_i,
    output logic [31:0]  dout_32b_o,
    output logic         dout_32b_valid_o,
    output logic         interrupt_o,
    output logic         data_out_valid,
    output logic [133:0] data_out
);

    localparam int AW = $clog2(BUF_BEATS);

    state_t        state;
    logic [7:0]    idx;
    logic          busy;
    logic          irq_en;
    logic          done;
    logic          err;
    logic [10:0]   len;
    logic [6:0]    nbeats;
    logic [6:0]    sent;
    logic [3:0]    inv;
    logic [AW-1:0] rptr;
    logic [127:0]  q;
    logic [3:0]    we;
    logic [31:0]   rdata;
    logic          ctrl_wr;
    logic          stat_wr;
    logic          start;
    logic          len_ok;
    logic          unused_addr;

    assign idx         = addr_32b_i[9:2];
    assign unused_addr = ^{addr_32b_i[31:10], addr_32b_i[1:0]};
    assign busy        = (state != S_IDLE);
    assign ctrl_wr     = wren_i && (idx == OFF_CTRL);
    assign stat_wr     = wren_i && (idx == OFF_STAT);
    assign start       = ctrl_wr && din_32b_i[0] && !busy;
    assign len_ok      = (len >= LEN_MIN) && (len <= LEN_MAX);
    assign interrupt_o = done & irq_en;

    assign we = (wren_i && idx[7] && !busy) ?
                (4'b0001 << idx[1:0]) : 4'b0000;

    mem_pkt_tx_buf #(
        .DEPTH (BUF_BEATS),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (AW'(idx[6:2])),
        .wdata (din_32b_i),
        .raddr (rptr),
        .q     (q)
    );

    always_comb begin
        rdata = 32'd0;
        case (idx)
            OFF_CTRL: rdata = {28'd0, err, done, irq_en, busy};
            OFF_LEN:  rdata = {21'd0, len};
            OFF_STAT: rdata = {28'd0, err, done, 2'b00};
            default:  rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_32b_valid_o <= 1'b0;
            dout_32b_o       <= 32'd0;
        end else begin
            dout_32b_valid_o <= wren_i | rden_i;
            dout_32b_o       <= rden_i ? rdata : 32'd0;
        end
    end

    // The buffer reads rptr every cycle; beat k is in q
    // one cycle after rptr==k, so the output lags by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            irq_en         <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            len            <= 11'd0;
            nbeats         <= 7'd0;
            sent           <= 7'd0;
            inv            <= 4'd0;
            rptr           <= '0;
            data_out_valid <= 1'b0;
            data_out       <= '0;
        end else begin
            data_out_valid <= 1'b0;
            data_out       <= '0;
            if (ctrl_wr) begin
                irq_en <= din_32b_i[1];
            end
            if (wren_i && idx == OFF_LEN && !busy) begin
                len <= din_32b_i[10:0];
            end
            if (stat_wr && din_32b_i[2]) begin
                done <= 1'b0;
            end
            if (stat_wr && din_32b_i[3]) begin
                err <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (start && len_ok) begin
                        state  <= S_PREP;
                        nbeats <= beat_count(len);
                        inv    <= 4'd0 - len[3:0];
                        rptr   <= AW'(1);
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                S_PREP: begin
                    state          <= S_SEND;
                    data_out_valid <= 1'b1;
                    data_out       <= {TAG_HEAD, 4'd0, q};
                    sent           <= 7'd1;
                    rptr           <= rptr + AW'(1);
                end
                S_SEND: begin
                    data_out_valid <= 1'b1;
                    sent           <= sent + 7'd1;
                    rptr           <= rptr + AW'(1);
                    if (sent == nbeats - 7'd1) begin
                        data_out <= {TAG_TAIL, inv, q};
                        state    <= S_IDLE;
                        done     <= 1'b1;
                        rptr     <= '0;
                    end else begin
                        data_out <= {TAG_BODY, 4'd0, q};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_pkt_tx.sv
// Directed and randomized bench for mem_pkt_tx with a
// word-array buffer model and captured-beat scoreboard.
module tb_mem_pkt_tx;

    logic         clk;
    logic         rst;
    logic [31:0]  addr;
    logic         wren;
    logic         rden;
    logic [31:0]  din;
    logic [31:0]  dout;
    logic         ack;
    logic         irq;
    logic         valid;
    logic [133:0] data_out;

    int nasrt = 0;
    int nfail = 0;
    int cyc = 0;
    int bad_idle = 0;
    int last_wr_cyc = 0;

    logic [31:0]  words [128];
    logic         m_irq = 1'b0;
    logic         m_done = 1'b0;
    logic         m_err = 1'b0;
    logic [133:0] cap_q [$];
    int           cap_t [$];

    mem_pkt_tx #(
        .BUF_BEATS (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .addr_32b_i       (addr),
        .wren_i           (wren),
        .rden_i           (rden),
        .din_32b_i        (din),
        .dout_32b_o       (dout),
        .dout_32b_valid_o (ack),
        .interrupt_o      (irq),
        .data_out_valid   (valid),
        .data_out         (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            cap_q.push_back(data_out);
            cap_t.push_back(cyc);
        end else if (valid === 1'b0 && data_out !== '0) begin
            bad_idle <= bad_idle + 1;
        end
    end

    task automatic check(input string tag,
                         input logic [255:0] obs,
                         input logic [255:0] exp);
        nasrt++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_exp(input logic busy);
        return {28'd0, m_err, m_done, m_irq, busy};
    endfunction

    function automatic logic [133:0] exp_beat(int b, int n, int len);
        logic [1:0] tag;
        logic [3:0] inv;
        tag = (b == 0) ? 2'b01 : (b == n - 1) ? 2'b10 : 2'b00;
        inv = (b == n - 1) ? 4'(16 * n - len) : 4'd0;
        return {tag, inv, words[4*b], words[4*b+1],
                words[4*b+2], words[4*b+3]};
    endfunction

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din = d;
        wren = 1'b1;
        last_wr_cyc = cyc;
        @(negedge clk);
        wren = 1'b0;
        check("wr_ack", 256'({ack, dout}), 256'({1'b1, 32'd0}));
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp,
                          input string tag);
        @(negedge clk);
        addr = a;
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        check(tag, 256'({ack, dout}), 256'({1'b1, exp}));
    endtask

    task automatic buf_wr(input int w, input logic [31:0] d);
        bus_wr(32'h200 + 32'(w * 4), d);
        words[w] = d;
    endtask

    task automatic start(input logic irq_bit, output int s);
        bus_wr(32'h0, {30'd0, irq_bit, 1'b1});
        s = last_wr_cyc;
        m_irq = irq_bit;
    endtask

    task automatic check_pkt(input int len, input int s, input int off);
        int n;
        n = (len + 15) / 16;
        for (int b = 0; b < n; b++) begin
            check("beat", 256'(cap_q[off+b]), 256'(exp_beat(b, n, len)));
            check("beat_cyc", 256'(cap_t[off+b]), 256'(s + 2 + b));
        end
    endtask

    task automatic run_pkt(input int len, input logic irq_bit);
        int n;
        int s;
        n = (len + 15) / 16;
        cap_q.delete();
        cap_t.delete();
        start(irq_bit, s);
        repeat (n + 3) @(negedge clk);
        check("pkt_beats", 256'(cap_q.size()), 256'(n));
        check_pkt(len, s, 0);
        m_done = 1'b1;
    endtask

    initial begin
        int s;
        int s2;
        int len;
        rst = 1'b1;
        wren = 1'b0;
        rden = 1'b0;
        addr = 32'd0;
        din = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_outs", 256'({ack, dout, irq, valid, data_out}), 256'(0));
        rst = 1'b0;
        bus_rd(32'h0, 32'd0, "ctrl_rst");
        @(negedge clk);
        check("ack_pulse", 256'({ack, dout}), 256'(0));
        bus_rd(32'h4, 32'd0, "len_rst");

        for (int w = 0; w < 128; w++) buf_wr(w, $urandom);
        buf_wr(0, 32'h11223344);

        // 64-byte packet, known head word
        bus_wr(32'h4, 32'd64);
        bus_rd(32'h4, 32'd64, "len_rd");
        run_pkt(64, 1'b0);
        check("head_word", 256'(cap_q[0][127:96]), 256'(32'h11223344));
        check("tail_inv64", 256'(cap_q[3][131:128]), 256'(0));
        bus_rd(32'h0, ctrl_exp(1'b0), "ctrl_done");
        check("irq_masked", 256'(irq), 256'(0));

        // 33 bytes: 15 invalid trailing bytes, interrupt path
        bus_wr(32'h8, 32'h4);
        m_done = 1'b0;
        bus_wr(32'h4, 32'd33);
        run_pkt(33, 1'b1);
        check("tail_inv33", 256'(cap_q[2][131:128]), 256'(15));
        check("irq_set", 256'(irq), 256'(1));
        bus_wr(32'h8, 32'h4);
        m_done = 1'b0;
        check("irq_clr", 256'(irq), 256'(0));

        // Out-of-range lengths
        bus_wr(32'h4, 32'd16);
        cap_q.delete();
        start(1'b0, s);
        m_err = 1'b1;
        repeat (6) @(negedge clk);
        check("len16_none", 256'(cap_q.size()), 256'(0));
        bus_rd(32'h0, ctrl_exp(1'b0), "ctrl_err16");
        bus_wr(32'h8, 32'h8);
        m_err = 1'b0;
        bus_wr(32'h4, 32'd513);
        start(1'b0, s);
        m_err = 1'b1;
        repeat (6) @(negedge clk);
        check("len513_none", 256'(cap_q.size()), 256'(0));
        bus_rd(32'h0, ctrl_exp(1'b0), "ctrl_err513");
        bus_wr(32'h8, 32'h8);
        m_err = 1'b0;

        // Writes while busy are ignored
        bus_wr(32'h4, 32'd200);
        cap_q.delete();
        cap_t.delete();
        start(1'b0, s);
        bus_rd(32'h0, ctrl_exp(1'b1), "ctrl_busy");
        bus_wr(32'h4, 32'd40);
        bus_wr(32'h0, 32'h1);
        bus_wr(32'h200, 32'hDEADBEEF);
        bus_rd(32'h4, 32'd200, "len_busy");
        repeat (12) @(negedge clk);
        check("busy_beats", 256'(cap_q.size()), 256'(13));
        check_pkt(200, s, 0);
        m_done = 1'b1;
        bus_rd(32'h4, 32'd200, "len_after");

        // Done set beats W1C; back-to-back start after tail
        bus_wr(32'h8, 32'h4);
        m_done = 1'b0;
        bus_wr(32'h4, 32'd32);
        cap_q.delete();
        cap_t.delete();
        start(1'b0, s);
        bus_wr(32'h8, 32'h4);
        start(1'b0, s2);
        repeat (5) @(negedge clk);
        m_done = 1'b1;
        check("b2b_beats", 256'(cap_q.size()), 256'(4));
        check_pkt(32, s, 0);
        check_pkt(32, s2, 2);
        bus_rd(32'h0, ctrl_exp(1'b0), "ctrl_set_wins");

        for (int i = 0; i < 4; i++) begin
            len = int'($urandom_range(32, 512));
            for (int k = 0; k < 8; k++) buf_wr(int'($urandom_range(0, 127)), $urandom);
            bus_wr(32'h4, 32'(len));
            run_pkt(len, 1'b0);
        end

        // Unmapped and write-only regions
        bus_wr(32'h00C, 32'hFFFF_FFFF);
        bus_rd(32'h00C, 32'd0, "unmapped_rd");
        bus_rd(32'h200, 32'd0, "buf_rd0");
        bus_rd(32'h3FC, 32'd0, "buf_rd_last");

        // Reset during a 32-beat packet
        bus_wr(32'h4, 32'd512);
        cap_q.delete();
        cap_t.delete();
        start(1'b1, s);
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_drop", 256'({valid, data_out}), 256'(0));
        check("rst_beats", 256'(cap_q.size()), 256'(3));
        rst = 1'b0;
        m_irq = 1'b0;
        m_done = 1'b0;
        m_err = 1'b0;
        bus_rd(32'h0, 32'd0, "ctrl_after_rst");
        bus_rd(32'h4, 32'd0, "len_after_rst");
        check("irq_after_rst", 256'(irq), 256'(0));

        check("idle_zero", 256'(bad_idle), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasrt, nfail);
        $finish;
    end

endmodule

// File: doc/mem_pkt_tx.md
MEM_PKT_TX -- requirements
Module: mem_pkt_tx

Interface
REQ-001 SHALL have parameter BUF_BEATS, default 32, buffer depth in 128-bit beats (512 bytes).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port addr_32b_i  input  32  bus address; only [9:2] decoded.
REQ-005 SHALL have ports wren_i, rden_i  input  1 each  bus write/read strobe, one-cycle.
REQ-006 SHALL have port din_32b_i  input  32  bus write data.
REQ-007 SHALL have port dout_32b_o  output  32  bus read data.
REQ-008 SHALL have port dout_32b_valid_o  output  1  read/write acknowledge.
REQ-009 SHALL have port interrupt_o  output  1  level interrupt.
REQ-010 SHALL have port data_out_valid  output  1  packet beat valid.
REQ-011 SHALL have port data_out  output  134  beat: [133:132] tag (01 head, 00 body, 10 tail), [131:128] invalid trailing bytes (tail only, else 0), [127:0] data.

Function
REQ-012 Register map SHALL be: 0x000 CTRL (W: bit0 start, bit1 irq_en; R: bit0 busy, bit1 irq_en, bit2 done, bit3 err); 0x004 LEN (bytes, 11 bits R/W); 0x008 STAT (W1C: bit2 done, bit3 err); 0x200-0x3FC BUF (write-only, reads return 0).
REQ-013 BUF word w SHALL land in beat w>>2, lane (w&3), lane 0 = data[127:96] (network order).
REQ-014 dout_32b_valid_o SHALL pulse exactly one cycle after any wren_i or rden_i; dout_32b_o SHALL be 0 outside that cycle.
REQ-015 Unmapped offsets SHALL read 0 and ignore writes, still acknowledged.
REQ-016 FSM SHALL have states IDLE, PREP, SEND.
REQ-017 IDLE->PREP on CTRL write with bit0=1 and LEN in 32..512; buffer read of beat 0 issued.
REQ-018 Start with LEN outside 32..512 SHALL set err, stay IDLE, emit nothing.
REQ-019 PREP->SEND next cycle; head beat SHALL appear on data_out two cycles after the start write cycle.
REQ-020 SEND SHALL emit one beat per cycle, no gaps; beat count N = ceil(LEN/16); last beat tag 10 with [131:128] = 16*N - LEN.
REQ-021 On tail cycle, FSM SHALL return to IDLE and set done; data_out_valid deasserts the following cycle and data_out holds 0.
REQ-022 busy SHALL read 1 in PREP and SEND.
REQ-023 Start, LEN and BUF writes while busy SHALL be ignored (acknowledged, no effect); irq_en writes SHALL take effect.
REQ-024 Done set and W1C in same cycle: set SHALL win.
REQ-025 interrupt_o SHALL equal done AND irq_en, combinational from registers.
REQ-026 Back-to-back packets: start accepted the cycle after tail (IDLE) SHALL produce head two cycles later; one idle beat minimum between packets.

Reset
REQ-027 On rst all outputs SHALL be 0, FSM IDLE, CTRL/LEN/STAT 0; buffer contents undefined.
REQ-028 rst mid-SEND SHALL drop data_out_valid on the next edge without emitting tail, and done SHALL stay 0.

Structure
REQ-029 Package mem_pkt_tx_pkg SHALL hold tag constants, register offsets, LEN_MIN=32, LEN_MAX=512, FSM state enum.
REQ-030 Sub-module mem_pkt_tx_buf SHALL be a simple dual-port BUF_BEATSx128 RAM, 32-bit lane write enables, 1-cycle synchronous read.

Verification
REQ-031 Write 0x11223344 to 0x200, LEN=64, start -> 4 beats, head data[127:96]=0x11223344, tag sequence 01,00,00,10, tail [131:128]=0, done=1.
REQ-032 LEN=33 -> 3 beats, tail [131:128]=15; irq_en=1 -> interrupt_o=1 after tail; W1C 0x4 to STAT -> interrupt_o=0.
REQ-033 LEN=16 start -> err=1, data_out_valid stays 0; LEN=513 likewise.
REQ-034 Start while busy and LEN write during SEND -> beat count unchanged, LEN reads old value.
REQ-035 rst asserted during beat 2 of 32-beat packet -> data_out_valid=0 next cycle, CTRL reads 0.
REQ-036 Read CTRL -> dout_32b_valid_o one cycle later with busy reflected; read 0x200 -> 0.
